ahb_lite_mem_slave: RTL and testbench
=====================================

Name: ahb_lite_mem_slave

Overview:
- AHB-Lite slave (responder) backed by an internal word-organised memory.
- It is the far end of the AHB-Lite master port driven by the instruction-cache controller. It serves cache line-fill bursts and single fetches, and also accepts byte, halfword and word writes so benches and loaders can preload code.
- It inserts programmable wait states and returns two-cycle ERROR responses for illegal accesses.

Parameters:
- MEM_WORDS, 1024: memory depth in 32-bit words; a power of 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_STATES, 0: number of HREADYOUT=0 cycles inserted before each OKAY data phase; range 0–15.

Ports:
- HCLK, input, 1: bus clock.
- HRESETn, input, 1: asynchronous active-low reset.
- HSEL, input, 1: slave select from the decoder.
- HADDR, input, 32: byte address.
- HTRANS, input, 2: transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE, input, 1: 1 = write.
- HSIZE, input, 3: transfer size: 0 = byte, 1 = half, 2 = word.
- HBURST, input, 3: burst type; informational only.
- HWDATA, input, 32: write data, valid in the data phase.
- HREADY, input, 1: bus-level ready (mux output).
- HREADYOUT, output, 1: this slave's ready.
- HRESP, output, 1: 0 = OKAY, 1 = ERROR.
- HRDATA, output, 32: read data.

Behaviour:
- Reset: one clock (HCLK); reset is asynchronous and active-low (HRESETn).
  - While HRESETn=0: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer abandons the transfer; no partial write is committed.
- Address-phase capture: occurs on a rising edge when HSEL & HREADY & HTRANS[1].
  - Latched: HADDR, HWRITE, HSIZE.
  - The transfer is classified as legal or illegal at capture.
  - HTRANS IDLE or BUSY with HSEL, or HSEL=0: no access; the next data phase is zero-wait OKAY.
- Illegal transfer: any of
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0] != 0;
  - (HADDR - BASE_ADDR) >= MEM_WORDS*4, unsigned 32-bit compare.
- State machine states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
    - Legal capture with WAIT_STATES=0 -> DATA.
    - Legal capture with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES.
    - Illegal capture -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle. A new capture in the same cycle follows the IDLE rules; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A capture here follows the IDLE rules; the master should drive IDLE or retry.
- Read data: in DATA with a latched read, HRDATA = mem[(addr-BASE_ADDR)>>2], the full word regardless of size. HRDATA=0 in every other cycle.
- Write data: in DATA with a latched write, HWDATA is sampled at the end of that cycle. Byte lanes are little-endian:
  - byte: lane = addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all lanes.
  - Unselected bytes are unchanged.
- Pipelining and latency:
  - Latency from capture to completion is WAIT_STATES+1 cycles.
  - With WAIT_STATES=0, back-to-back NONSEQ/SEQ beats complete one per cycle; an INCR4/WRAP4 burst takes 4 data cycles.
  - Each beat is decoded from its own HADDR; wrap address generation is the master's job.
- Read-after-write: a read whose address phase overlaps a write's data phase to the same word returns the newly written bytes.
- Error transfers never write memory.
- Wait states apply only to legal NONSEQ/SEQ data phases.

Test Plan:
- Reset with HRESETn=0 mid-WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately, asynchronously; memory word 0 keeps its prior value.
- WAIT_STATES=0: word write 0xDEADBEEF @0x0, then NONSEQ read @0x0 -> HREADYOUT stays 1; read data phase shows HRDATA=0xDEADBEEF.
- Byte write 0xAA @0x5, then half write 0x1234 @0x6 over an existing word 0x00000000 at 0x4 -> read @0x4 returns 0x1234AA00.
- WAIT_STATES=2: INCR4 read @0x10..0x1C holding 1,2,3,4 -> each beat shows HREADYOUT 0,0,1; HRDATA is 1,2,3,4 on the ready cycles; 12 data cycles total.
- Word read @0x2, and read at BASE_ADDR+MEM_WORDS*4 -> each gives HRESP=1 for 2 cycles with HREADYOUT 0 then 1, regardless of WAIT_STATES; a following legal read returns OKAY.
- HTRANS=BUSY inside a burst, and HSEL=0 with HTRANS=NONSEQ -> zero-wait OKAY, no memory change, HRDATA=0.

Source files
------------

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite responder backed by a word-organised memory, with programmable
// wait states and two-cycle ERROR responses for misaligned or out-of-range accesses.
module ahb_lite_mem_slave #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] word_q, word_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;

    logic [31:0]   mem [MEM_WORDS];

    logic [31:0]   offset;
    logic          align_ok;
    logic          range_ok;
    logic          legal;
    logic          slave_ready;
    logic          capture;
    logic [3:0]    byte_en;
    logic          mem_we;
    logic          unused_bus;

    // HBURST is informational and HTRANS[0] only separates NONSEQ from SEQ,
    // neither of which changes how a beat is served.
    assign unused_bus = ^{HBURST, HTRANS[0]};

    assign offset = HADDR - BASE_ADDR;

    always_comb begin
        align_ok = 1'b0;
        case (HSIZE)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = ~HADDR[0];
            3'd2:    align_ok = (HADDR[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign range_ok    = ({1'b0, offset} < MEM_BYTES);
    assign legal       = align_ok & range_ok;
    assign slave_ready = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
    assign capture     = HSEL & HREADY & HTRANS[1] & slave_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        word_d     = word_q;
        lane_d     = lane_q;
        size_d     = size_q;
        write_d    = write_q;
        case (state_q)
            ST_WAIT: begin
                wait_cnt_d = (wait_cnt_q == 4'd0) ? 4'd0 : wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all present HREADYOUT=1, so each can take a new address phase.
                if (capture) begin
                    word_d  = offset[AW+1:2];
                    lane_d  = HADDR[1:0];
                    size_d  = HSIZE[1:0];
                    write_d = HWRITE;
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WS == 4'd0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            word_q     <= '0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            write_q    <= write_d;
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en = 4'b0001 << lane_q;
            2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    assign mem_we = (state_q == ST_DATA) & write_q;

    // Storage is deliberately unreset; a reset drops state_q to IDLE, which kills any pending write.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign HREADYOUT = ~((state_q == ST_WAIT) | (state_q == ST_ERR1));
    assign HRESP     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem[word_q] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Randomised bench for ahb_lite_mem_slave: two instances (zero and two wait states)
// driven by a pipelined bus master and checked cycle by cycle against a byte-level memory model.
module tb_ahb_lite_mem_slave;

    localparam logic [31:0] BASE2 = 32'h2000_0000;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        bit          write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } beat_t;

    logic        clk;
    logic        rst_n_0, rst_n_2;
    logic        hsel_0, hsel_2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hreadyout_0, hresp_0;
    logic        hreadyout_2, hresp_2;
    logic [31:0] hrdata_0, hrdata_2;

    int          n_compared;
    int          n_mismatched;
    beat_t       q[$];
    logic [7:0]  ref_b [2][4096];

    ahb_lite_mem_slave #(
        .MEM_WORDS  (1024),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_STATES(0)
    ) dut_ws0 (
        .HCLK     (clk),
        .HRESETn  (rst_n_0),
        .HSEL     (hsel_0),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HBURST   (hburst),
        .HWDATA   (hwdata),
        .HREADY   (hreadyout_0),
        .HREADYOUT(hreadyout_0),
        .HRESP    (hresp_0),
        .HRDATA   (hrdata_0)
    );

    ahb_lite_mem_slave #(
        .MEM_WORDS  (256),
        .BASE_ADDR  (BASE2),
        .WAIT_STATES(2)
    ) dut_ws2 (
        .HCLK     (clk),
        .HRESETn  (rst_n_2),
        .HSEL     (hsel_2),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HBURST   (hburst),
        .HWDATA   (hwdata),
        .HREADY   (hreadyout_2),
        .HREADYOUT(hreadyout_2),
        .HRESP    (hresp_2),
        .HRDATA   (hrdata_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? BASE2 : 32'h0;
    endfunction

    function automatic logic [31:0] bytes_of(input int d);
        return (d == 1) ? 32'd1024 : 32'd4096;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic bit is_legal(input int d, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] off;
        off = a - base_of(d);
        if (sz > 3'd2) return 1'b0;
        if (sz == 3'd1 && a[0]) return 1'b0;
        if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
        if (off >= bytes_of(d)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
        int w;
        w = int'((a - base_of(d)) & 32'hFFFF_FFFC);
        return {ref_b[d][w+3], ref_b[d][w+2], ref_b[d][w+1], ref_b[d][w]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd);
        logic [31:0] off;
        int          w;
        bit          en;
        off = a - base_of(d);
        w   = int'(off & 32'hFFFF_FFFC);
        for (int l = 0; l < 4; l++) begin
            if (sz == 3'd0)      en = (l == int'(off[1:0]));
            else if (sz == 3'd1) en = ((l / 2) == int'(off[1]));
            else                 en = 1'b1;
            if (en) ref_b[d][w+l] = wd[l*8 +: 8];
        end
    endtask

    task automatic add_beat(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                            input bit write, input logic [2:0] size, input logic [31:0] wdata);
        beat_t b;
        b.sel   = sel;
        b.trans = trans;
        b.addr  = addr;
        b.write = write;
        b.size  = size;
        b.wdata = wdata;
        q.push_back(b);
    endtask

    task automatic drive_idle();
        hsel_0 = 1'b0;
        hsel_2 = 1'b0;
        htrans = 2'd0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hburst = 3'd0;
    endtask

    task automatic drive_addr(input int d, input beat_t b);
        hsel_0 = (d == 0) && b.sel;
        hsel_2 = (d == 1) && b.sel;
        htrans = b.trans;
        haddr  = b.addr;
        hwrite = b.write;
        hsize  = b.size;
        hburst = 3'd3;
    endtask

    // Plays the queued beats through a pipelined master and checks every data-phase cycle.
    task automatic applyStimulus(input int d, output int data_cycles);
        int          i;
        int          dp_cycles;
        int          guard;
        bit          have_dp;
        beat_t       dp;
        logic        rdy, resp;
        logic [31:0] rdata;
        logic        exp_rdy, exp_resp;
        logic [31:0] exp_data;
        bit          act, leg;
        i           = 0;
        dp_cycles   = 0;
        guard       = 0;
        have_dp     = 1'b0;
        data_cycles = 0;
        dp          = '{default: '0};
        @(posedge clk);
        #1;
        while ((i < q.size() || have_dp) && guard < 600) begin
            guard++;
            if (i < q.size()) drive_addr(d, q[i]);
            else drive_idle();
            hwdata = have_dp ? dp.wdata : $urandom;
            @(negedge clk);
            rdy   = (d == 1) ? hreadyout_2 : hreadyout_0;
            resp  = (d == 1) ? hresp_2 : hresp_0;
            rdata = (d == 1) ? hrdata_2 : hrdata_0;
            if (have_dp) begin
                data_cycles++;
                act      = dp.sel && dp.trans[1];
                leg      = is_legal(d, dp.addr, dp.size);
                exp_data = 32'h0;
                if (!act) begin
                    exp_rdy  = 1'b1;
                    exp_resp = 1'b0;
                end else if (!leg) begin
                    exp_rdy  = (dp_cycles != 0);
                    exp_resp = 1'b1;
                end else begin
                    exp_rdy  = (dp_cycles >= ws_of(d));
                    exp_resp = 1'b0;
                    if (exp_rdy && !dp.write) exp_data = model_word(d, dp.addr);
                end
                checkOutput($sformatf("d%0d hreadyout @%08h", d, dp.addr), {31'd0, rdy}, {31'd0, exp_rdy});
                checkOutput($sformatf("d%0d hresp @%08h", d, dp.addr), {31'd0, resp}, {31'd0, exp_resp});
                checkOutput($sformatf("d%0d hrdata @%08h", d, dp.addr), rdata, exp_data);
                if (dp_cycles > 20) begin
                    checkOutput($sformatf("d%0d ready_timeout", d), {31'd0, rdy}, 32'd1);
                    break;
                end
                if (rdy && act && leg && dp.write) model_write(d, dp.addr, dp.size, dp.wdata);
            end else begin
                checkOutput($sformatf("d%0d idle hreadyout", d), {31'd0, rdy}, 32'd1);
            end
            @(posedge clk);
            if (rdy) begin
                if (i < q.size()) begin
                    dp      = q[i];
                    have_dp = 1'b1;
                    i++;
                end else begin
                    have_dp = 1'b0;
                end
                dp_cycles = 0;
            end else begin
                dp_cycles++;
            end
            #1;
        end
        if (have_dp || i < q.size()) checkOutput($sformatf("d%0d sequence_complete", d), i, q.size() + 1);
        drive_idle();
        q.delete();
    endtask

    function automatic logic [31:0] rand_addr(input int d, input logic [2:0] sz);
        int          r;
        logic [31:0] off;
        r = $urandom_range(0, 19);
        if (r == 0) begin
            off = bytes_of(d) + ($urandom_range(0, 63) << 2);
        end else if (r == 1) begin
            off = 32'hFFFF_FFFC;
        end else begin
            off = $urandom_range(0, 127);
            if (r > 4) begin
                if (sz == 3'd1) off[0] = 1'b0;
                if (sz == 3'd2) off[1:0] = 2'b00;
            end
        end
        return base_of(d) + off;
    endfunction

    task automatic random_beats(input int d, input int n);
        int          r;
        logic [1:0]  tr;
        logic [2:0]  sz;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      tr = 2'd0;
            else if (r == 1) tr = 2'd1;
            else if (r < 6)  tr = 2'd2;
            else             tr = 2'd3;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            add_beat($urandom_range(0, 9) != 0, tr, rand_addr(d, sz), $urandom_range(0, 1) == 1, sz, $urandom);
        end
    endtask

    initial begin
        int cyc;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n_0      = 1'b0;
        rst_n_2      = 1'b0;
        hwdata       = 32'h0;
        drive_idle();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 4096; b++) ref_b[d][b] = 8'h00;
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset d0 hreadyout", {31'd0, hreadyout_0}, 32'd1);
        checkOutput("reset d0 hresp", {31'd0, hresp_0}, 32'd0);
        checkOutput("reset d0 hrdata", hrdata_0, 32'd0);
        checkOutput("reset d2 hreadyout", {31'd0, hreadyout_2}, 32'd1);
        checkOutput("reset d2 hresp", {31'd0, hresp_2}, 32'd0);
        checkOutput("reset d2 hrdata", hrdata_2, 32'd0);
        rst_n_0 = 1'b1;
        rst_n_2 = 1'b1;

        // Preload a 128-byte window in each instance; 0x4 is zero and 0x10..0x1C hold 1..4.
        for (int w = 0; w < 32; w++) begin
            add_beat(1'b1, 2'd2, 32'(w * 4), 1'b1, 3'd2, (w == 1) ? 32'h0 : $urandom);
        end
        applyStimulus(0, cyc);
        for (int w = 0; w < 32; w++) begin
            add_beat(1'b1, 2'd2, BASE2 + 32'(w * 4), 1'b1, 3'd2,
                     (w >= 4 && w <= 7) ? 32'(w - 3) : $urandom);
        end
        applyStimulus(1, cyc);

        $display("[TB] word write / read-back and sub-word lane writes");
        add_beat(1'b1, 2'd2, 32'h0, 1'b1, 3'd2, 32'hDEAD_BEEF);
        add_beat(1'b1, 2'd2, 32'h0, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, 32'h5, 1'b1, 3'd0, 32'h5566_AA77);
        add_beat(1'b1, 2'd2, 32'h6, 1'b1, 3'd1, 32'h1234_9999);
        add_beat(1'b1, 2'd2, 32'h4, 1'b0, 3'd2, 32'h0);
        applyStimulus(0, cyc);

        $display("[TB] INCR4 read with two wait states");
        add_beat(1'b1, 2'd2, BASE2 + 32'h10, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd3, BASE2 + 32'h14, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd3, BASE2 + 32'h18, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd3, BASE2 + 32'h1C, 1'b0, 3'd2, 32'h0);
        applyStimulus(1, cyc);
        checkOutput("incr4 data cycles", cyc, 32'd12);

        $display("[TB] error responses");
        add_beat(1'b1, 2'd2, 32'h2, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, 32'h0, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, 32'h1000, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, 32'h8, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, 32'h1000, 1'b1, 3'd2, 32'h0BAD_0BAD);
        add_beat(1'b1, 2'd2, 32'hC, 1'b0, 3'd2, 32'h0);
        applyStimulus(0, cyc);
        add_beat(1'b1, 2'd2, BASE2 + 32'h2, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, BASE2 + 32'h400, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd2, BASE2 - 32'h4, 1'b1, 3'd2, 32'h0BAD_0BAD);
        add_beat(1'b1, 2'd2, BASE2 + 32'h3, 1'b1, 3'd1, 32'h0BAD_0BAD);
        add_beat(1'b1, 2'd2, BASE2 + 32'h0, 1'b0, 3'd2, 32'h0);
        applyStimulus(1, cyc);

        $display("[TB] BUSY inside a burst and deselected transfers");
        add_beat(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'h0);
        add_beat(1'b1, 2'd1, 32'h14, 1'b1, 3'd2, 32'hFFFF_FFFF);
        add_beat(1'b1, 2'd3, 32'h14, 1'b0, 3'd2, 32'h0);
        add_beat(1'b0, 2'd2, 32'h8, 1'b1, 3'd2, 32'h1111_2222);
        add_beat(1'b1, 2'd2, 32'h8, 1'b0, 3'd2, 32'h0);
        applyStimulus(0, cyc);

        $display("[TB] reset in the middle of a waited write");
        @(posedge clk);
        #1;
        hsel_2 = 1'b1;
        haddr  = BASE2;
        htrans = 2'd2;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("wait before reset hreadyout", {31'd0, hreadyout_2}, 32'd0);
        #2;
        rst_n_2 = 1'b0;
        #1;
        checkOutput("async reset hreadyout", {31'd0, hreadyout_2}, 32'd1);
        checkOutput("async reset hresp", {31'd0, hresp_2}, 32'd0);
        checkOutput("async reset hrdata", hrdata_2, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n_2 = 1'b1;
        add_beat(1'b1, 2'd2, BASE2, 1'b0, 3'd2, 32'h0);
        applyStimulus(1, cyc);

        $display("[TB] randomised traffic");
        for (int r = 0; r < 4; r++) begin
            random_beats(0, 40);
            applyStimulus(0, cyc);
            random_beats(1, 40);
            applyStimulus(1, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
